// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D-cache main-memory arbiter.
// Round-robin tie-break is enabled by defining ARB_RR_EN.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

    localparam int WORD_IDX_W     = 3;
    localparam int BLOCK_OFFSET_W = 4;

endpackage

// File: rtl/cache_mem_arbiter_select.sv
// Combinational winner pick between I and D requesters.
// On a tie, I wins only when D was served last.
module arb_select (
    input  logic i_req,
    input  logic d_req,
    input  logic last_d,
    output logic pick_i,
    output logic pick_d
);

    assign pick_i = i_req & (~d_req | last_d);
    assign pick_d = d_req & ~pick_i;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the main-memory port between I-cache and D-cache fills/writes.
// Define ARB_RR_EN for round-robin tie-break; default is fixed D priority.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_req,
    input  logic [ADDR_W-1:0]                  i_addr,
    output logic                               i_grant,
    output logic                               i_data_valid,
    output logic                               i_done,
    input  logic                               d_req,
    input  logic                               d_wr,
    input  logic [ADDR_W-1:0]                  d_addr,
    input  logic [DATA_W-1:0]                  d_wdata,
    output logic                               d_grant,
    output logic                               d_data_valid,
    output logic                               d_done,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic [DATA_W-1:0]                  mem_rdata,
    input  logic                               mem_rvalid
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS_PER_BLOCK - 1);

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [IDX_W:0]     issue_q;
    logic [IDX_W-1:0]   ret_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               pick_i, pick_d, last_d;
    logic               in_fill, in_write, issue_en, fill_hit;

`ifdef ARB_RR_EN
    logic last_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_d_q <= 1'b1;
        else if (state_q == ST_IDLE && (pick_i || pick_d))
            last_d_q <= pick_d;
    end

    assign last_d = last_d_q;
`else
    assign last_d = 1'b0;
`endif

    arb_select u_sel (
        .i_req  (i_req),
        .d_req  (d_req),
        .last_d (last_d),
        .pick_i (pick_i),
        .pick_d (pick_d)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    owner_d = OWN_D;
                    state_d = d_wr ? ST_WRITE : ST_FILL;
                end else if (pick_i) begin
                    owner_d = OWN_I;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_rvalid && ret_q == LAST)
                    state_d = ST_DONE;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            issue_q <= '0;
            ret_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (state_q == ST_IDLE) begin
                issue_q <= '0;
                ret_q   <= '0;
                addr_q  <= pick_d ? d_addr : i_addr;
                wdata_q <= d_wdata;
            end else if (in_fill) begin
                if (issue_en)
                    issue_q <= issue_q + 1'b1;
                if (mem_rvalid)
                    ret_q <= ret_q + 1'b1;
            end
        end
    end

    assign in_fill  = (state_q == ST_FILL);
    assign in_write = (state_q == ST_WRITE);
    // Top issue bit set means all block reads are out.
    assign issue_en = in_fill & ~issue_q[IDX_W];
    assign fill_hit = in_fill & mem_rvalid;

    assign i_grant      = (owner_q == OWN_I);
    assign d_grant      = (owner_q == OWN_D);
    assign i_data_valid = fill_hit & i_grant;
    assign d_data_valid = fill_hit & d_grant;
    assign i_done       = (state_q == ST_DONE) & i_grant;
    assign d_done       = (state_q == ST_DONE) & d_grant;
    assign fill_word    = fill_hit ? ret_q : '0;
    assign fill_data    = fill_hit ? mem_rdata : '0;

    assign mem_en    = issue_en | in_write;
    assign mem_wr    = in_write;
    assign mem_wdata = in_write ? wdata_q : '0;
    assign mem_addr  = issue_en ?
        {addr_q[ADDR_W-1:OFF_W], issue_q[IDX_W-1:0], 1'b0} :
        (in_write ? addr_q : '0);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter with a fixed-latency memory model.
// Tie expectations follow ARB_RR_EN when the bench is built with it.
module tb_cache_mem_arbiter;

    localparam int LAT = 4;

    logic        clk, rst_n;
    logic        i_req, i_grant, i_data_valid, i_done;
    logic [15:0] i_addr;
    logic        d_req, d_wr, d_grant, d_data_valid, d_done;
    logic [15:0] d_addr, d_wdata;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          stray;
    bit          m_last_d = 1'b1;

    logic [127:0] mem_q[$];
    logic [127:0] ret_q[$];
    logic [127:0] done_q[$];

    cache_mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_grant      (i_grant),
        .i_data_valid (i_data_valid),
        .i_done       (i_done),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_grant      (d_grant),
        .d_data_valid (d_data_valid),
        .d_done       (d_done),
        .fill_word    (fill_word),
        .fill_data    (fill_data),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_f(logic [15:0] a);
        return (a * 16'd7) ^ 16'h3C5A;
    endfunction

    function automatic logic [127:0] mk_mem(int c, logic wr,
        logic [15:0] a, logic [15:0] wd, logic ig, logic dg);
        return {61'd0, 32'(c), wr, a, wd, ig, dg};
    endfunction

    function automatic logic [127:0] mk_ret(int c, logic iv, logic dv,
        logic [2:0] w, logic [15:0] dat, logic ig, logic dg);
        return {73'd0, 32'(c), iv, dv, w, dat, ig, dg};
    endfunction

    function automatic logic [127:0] mk_done(int c, logic id, logic dd,
        logic ig, logic dg);
        return {92'd0, 32'(c), id, dd, ig, dg};
    endfunction

    function automatic logic [127:0] all_out();
        return {69'd0, i_grant, i_data_valid, i_done, d_grant,
                d_data_valid, d_done, fill_word, fill_data, mem_en,
                mem_wr, mem_addr, mem_wdata};
    endfunction

    // Memory: read issued in cycle c returns in cycle c+LAT.
    initial begin
        logic        pv[LAT];
        logic [15:0] pa[LAT];
        logic        nv;
        logic [15:0] na;
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 16'hDEAD;
        forever begin
            @(negedge clk);
            nv = mem_en & ~mem_wr;
            na = mem_addr;
            @(posedge clk);
            #2;
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[0] = nv;
            pa[0] = na;
            mem_rvalid = pv[LAT-1] | stray;
            mem_rdata  = pv[LAT-1] ? mem_f(pa[LAT-1]) : 16'hDEAD;
        end
    end

    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_q.size() == 0)
                chk("mem_unexp", mk_mem(cyc, mem_wr, mem_addr, mem_wdata,
                    i_grant, d_grant), '0);
            else
                chk("mem", mk_mem(cyc, mem_wr, mem_addr, mem_wdata,
                    i_grant, d_grant), mem_q.pop_front());
        end
        if (i_data_valid || d_data_valid) begin
            if (ret_q.size() == 0)
                chk("ret_unexp", mk_ret(cyc, i_data_valid, d_data_valid,
                    fill_word, fill_data, i_grant, d_grant), '0);
            else
                chk("ret", mk_ret(cyc, i_data_valid, d_data_valid,
                    fill_word, fill_data, i_grant, d_grant),
                    ret_q.pop_front());
        end
        if (i_done || d_done) begin
            if (done_q.size() == 0)
                chk("done_unexp", mk_done(cyc, i_done, d_done,
                    i_grant, d_grant), '0);
            else
                chk("done", mk_done(cyc, i_done, d_done,
                    i_grant, d_grant), done_q.pop_front());
        end
    end

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_fill(bit is_d, logic [15:0] a, int t0,
        int ni, int nr, bit wd);
        logic [15:0] ma;
        for (int k = 0; k < ni; k++) begin
            ma = {a[15:4], 3'(k), 1'b0};
            mem_q.push_back(mk_mem(t0 + 1 + k, 1'b0, ma, '0, !is_d, is_d));
        end
        for (int k = 0; k < nr; k++) begin
            ma = {a[15:4], 3'(k), 1'b0};
            ret_q.push_back(mk_ret(t0 + 1 + LAT + k, !is_d, is_d, 3'(k),
                mem_f(ma), !is_d, is_d));
        end
        if (wd)
            done_q.push_back(mk_done(t0 + 9 + LAT, !is_d, is_d,
                !is_d, is_d));
        m_last_d = is_d;
    endtask

    task automatic exp_write(logic [15:0] a, logic [15:0] wd, int t0);
        mem_q.push_back(mk_mem(t0 + 1, 1'b1, a, wd, 1'b0, 1'b1));
        done_q.push_back(mk_done(t0 + 2, 1'b0, 1'b1, 1'b0, 1'b1));
        m_last_d = 1'b1;
    endtask

    function automatic bit tie_winner_d();
`ifdef ARB_RR_EN
        return !m_last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tie_test();
        int t;
        bit wd;
        t = cyc + 2;
        goto(t);
        wd = tie_winner_d();
        exp_fill(wd, wd ? 16'h2000 : 16'h3000, t, 8, 8, 1);
        exp_fill(!wd, wd ? 16'h3000 : 16'h2000, t + 14, 8, 8, 1);
        i_req  = 1'b1;
        i_addr = 16'h3000;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h2000;
        goto(t + 14);
        if (wd)
            d_req = 1'b0;
        else
            i_req = 1'b0;
        goto(t + 28);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        int t;
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        stray   = 1'b0;
        goto(2);
        chk("reset_outs", all_out(), '0);
        rst_n = 1'b1;

        // Lone I fill with unaligned address
        t = cyc + 2;
        goto(t);
        exp_fill(1'b0, 16'h1236, t, 8, 8, 1);
        i_req  = 1'b1;
        i_addr = 16'h1236;
        goto(t + 14);
        i_req = 1'b0;

        // D write-through
        t = cyc + 2;
        goto(t);
        exp_write(16'h0040, 16'hBEEF, t);
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 16'hBEEF;
        goto(t + 3);
        d_req = 1'b0;
        d_wr  = 1'b0;

        tie_test();
        tie_test();

        // D request arrives while I fill runs
        t = cyc + 2;
        goto(t);
        exp_fill(1'b0, 16'h1100, t, 8, 8, 1);
        exp_write(16'h0080, 16'h1234, t + 14);
        i_req  = 1'b1;
        i_addr = 16'h1100;
        goto(t + 3);
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0080;
        d_wdata = 16'h1234;
        goto(t + 14);
        i_req = 1'b0;
        goto(t + 17);
        d_req = 1'b0;
        d_wr  = 1'b0;

        // Reset at the fourth return of a fill
        t = cyc + 2;
        goto(t);
        exp_fill(1'b0, 16'h4008, t, 7, 3, 0);
        i_req  = 1'b1;
        i_addr = 16'h4008;
        goto(t + 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", all_out(), '0);
        i_req = 1'b0;
        goto(t + 9);
        rst_n    = 1'b1;
        m_last_d = 1'b1;
        goto(t + 10);
        #2;
        chk("stray_after_rst", {mem_rvalid, i_data_valid, d_data_valid,
            fill_data}, {1'b1, 1'b0, 1'b0, 16'h0000});
        goto(t + 14);

        // Stray rvalid during DONE and IDLE, then a fresh D fill
        t = cyc + 2;
        goto(t);
        exp_fill(1'b0, 16'h5550, t, 8, 8, 1);
        i_req  = 1'b1;
        i_addr = 16'h5550;
        goto(t + 13);
        stray = 1'b1;
        #2;
        chk("stray_done", {mem_rvalid, i_data_valid, fill_word, i_done},
            {1'b1, 1'b0, 3'd0, 1'b1});
        goto(t + 14);
        i_req = 1'b0;
        goto(t + 15);
        stray = 1'b0;
        goto(t + 16);
        exp_fill(1'b1, 16'h6002, t + 16, 8, 8, 1);
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h6002;
        goto(t + 30);
        d_req = 1'b0;

        goto(cyc + 6);
        chk("mem_q_left", 128'(mem_q.size()), '0);
        chk("ret_q_left", 128'(ret_q.size()), '0);
        chk("done_q_left", 128'(done_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_err);
        $finish;
    end

endmodule
